// File: rtl/gs_mapper_pkg.sv
// gs_mapper_pkg: shared types and constants for the Z80 page mapper.
//   io_state_e  - I/O qualifier FSM states
//   page_reg_t  - one window page register {ram, wp, page[5:0]}
//   RAM_BIT/WP_BIT - bit positions of the flags in the I/O data byte
package gs_mapper_pkg;

    localparam int unsigned RAM_BIT    = 7;
    localparam int unsigned WP_BIT     = 6;
    localparam int unsigned MAX_PAGE_W = 6;
    // Register index width wide enough for the largest window count (16)
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HOLD = 2'd2
    } io_state_e;

    // Layout matches the I/O data byte, so a register packs directly to 8 bits
    typedef struct packed {
        logic                  ram;
        logic                  wp;
        logic [MAX_PAGE_W-1:0] page;
    } page_reg_t;

    function automatic page_reg_t make_reg(input logic ram, input logic wp,
                                           input logic [MAX_PAGE_W-1:0] page);
        page_reg_t r;
        r.ram  = ram;
        r.wp   = wp;
        r.page = page;
        return r;
    endfunction

endpackage

// File: rtl/gs_mapper_if.sv
// gs_mapper_if: Z80 bus as seen by the mapper.
//   master - CPU side: drives strobes, address and write data
//   slave  - mapper side: drives readback data and its enable
interface gs_mapper_if;

    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;

    modport master (
        output mreq_n, iorq_n, rd_n, wr_n, a, d_in,
        input  d_out, d_oe
    );

    modport slave (
        input  mreq_n, iorq_n, rd_n, wr_n, a, d_in,
        output d_out, d_oe
    );

endinterface

// File: rtl/gs_mapper_io_qual.sv
// gs_io_qual: two-sample strobe qualifier and I/O cycle FSM.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   hit_i            - mapper port decoded this sample
//   iorq_n_i, rd_n_i, wr_n_i - Z80 strobes
//   idx_i            - register index from the address
//   commit_c_o       - write commits on this edge (combinational)
//   rd_start_c_o     - a read cycle is being accepted on this edge
//   rd_active_o      - registered: accepted read cycle in progress
//   idx_o            - registered index latched at cycle start
module gs_io_qual
    import gs_mapper_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hit_i,
    input  logic             iorq_n_i,
    input  logic             rd_n_i,
    input  logic             wr_n_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             commit_c_o,
    output logic             rd_start_c_o,
    output logic             rd_active_o,
    output logic [IDX_W-1:0] idx_o
);

    io_state_e        state_q, state_d;
    logic             is_wr_q, is_wr_d;
    logic             rd_active_q, rd_active_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             strobe_lo;

    // The strobe that opened the cycle must still be low on the second sample
    assign strobe_lo = is_wr_q ? !wr_n_i : !rd_n_i;

    // Reset parks in HOLD so a cycle in flight at release never commits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HOLD;
            is_wr_q     <= 1'b0;
            rd_active_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            rd_active_q <= rd_active_d;
            idx_q       <= idx_d;
        end
    end

    // Next-state and pulse outputs
    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        idx_d        = idx_q;
        commit_c_o   = 1'b0;
        rd_start_c_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit_i && (!wr_n_i || !rd_n_i)) begin
                    state_d      = ST_QUAL;
                    is_wr_d      = !wr_n_i;
                    idx_d        = idx_i;
                    rd_start_c_o = wr_n_i;
                end
            end
            ST_QUAL: begin
                if (hit_i && strobe_lo) begin
                    state_d    = ST_HOLD;
                    commit_c_o = is_wr_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (iorq_n_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_active_d = rd_start_c_o || (rd_active_q && (state_d != ST_IDLE));
    end

    assign rd_active_o = rd_active_q;
    assign idx_o       = idx_q;

endmodule

// File: rtl/gs_mapper.sv
// gs_mapper: Z80 memory page mapper with NWIN windows of 64K/NWIN each.
//   clkin, coldres  - clock, synchronous active-high reset
//   z80 (slave)     - Z80 strobes, address, write data; readback d_out/d_oe
//   mema            - page number of the addressed window
//   romcs_n/ramcs_n - chip selects from the window's ram flag
//   memoe_n/memwe_n - memory strobes (write blocked by the wp flag)
// Optional: define GS_MAPPER_READBACK_EN to enable register readback on I/O reads.
module gs_mapper
    import gs_mapper_pkg::*;
#(
    parameter int unsigned NWIN      = 4,
    parameter int unsigned PAGE_W    = 6,
    parameter logic [7:0]  PORT_BASE = 8'h40
) (
    input  logic              clkin,
    input  logic              coldres,
    gs_mapper_if.slave        z80,
    output logic [PAGE_W-1:0] mema,
    output logic              romcs_n,
    output logic              ramcs_n,
    output logic              memoe_n,
    output logic              memwe_n
);

    localparam int unsigned         WIN_W     = $clog2(NWIN);
    localparam logic [7:0]          IDX_MASK  = 8'(NWIN - 1);
    localparam logic [MAX_PAGE_W-1:0] PAGE_MASK = MAX_PAGE_W'((1 << PAGE_W) - 1);

    page_reg_t        regs_q [NWIN];
    page_reg_t        regs_d [NWIN];
    logic             port_hit_c;
    logic [IDX_W-1:0] port_idx;
    logic [WIN_W-1:0] win;
    logic             mem_sel_c;
    logic             commit_c;
    logic             rd_start_c;
    logic             rd_active;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_bits;

    // Port decode: I/O-only cycle whose address matches the base ignoring index bits
    assign port_hit_c = !z80.iorq_n && z80.mreq_n &&
                        ((z80.a[7:0] & ~IDX_MASK) == PORT_BASE);
    assign port_idx   = IDX_W'(z80.a[WIN_W-1:0]);
    assign win        = z80.a[15 -: WIN_W];

    gs_io_qual u_qual (
        .clk_i        (clkin),
        .rst_i        (coldres),
        .hit_i        (port_hit_c),
        .iorq_n_i     (z80.iorq_n),
        .rd_n_i       (z80.rd_n),
        .wr_n_i       (z80.wr_n),
        .idx_i        (port_idx),
        .commit_c_o   (commit_c),
        .rd_start_c_o (rd_start_c),
        .rd_active_o  (rd_active),
        .idx_o        (wr_idx)
    );

    // Register write; an index that matches no window is simply dropped
    always_comb begin
        for (int i = 0; i < int'(NWIN); i++) begin
            regs_d[i] = regs_q[i];
            if (commit_c && (wr_idx == IDX_W'(i))) begin
                regs_d[i] = make_reg(z80.d_in[RAM_BIT], z80.d_in[WP_BIT],
                                     z80.d_in[MAX_PAGE_W-1:0] & PAGE_MASK);
            end
        end
    end

    // Page registers; reset maps window i to page i
    always_ff @(posedge clkin) begin
        for (int i = 0; i < int'(NWIN); i++) begin
            if (coldres) begin
                regs_q[i] <= make_reg(1'b0, 1'b0, MAX_PAGE_W'(i) & PAGE_MASK);
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Memory decode: only a pure memory cycle selects anything
    assign mem_sel_c = !z80.mreq_n && z80.iorq_n;

    always_comb begin
        mema    = '0;
        romcs_n = 1'b1;
        ramcs_n = 1'b1;
        memoe_n = 1'b1;
        memwe_n = 1'b1;
        if (mem_sel_c) begin
            mema    = regs_q[win].page[PAGE_W-1:0];
            romcs_n = regs_q[win].ram;
            ramcs_n = !regs_q[win].ram;
            memoe_n = z80.rd_n;
            memwe_n = z80.wr_n | regs_q[win].wp;
        end
    end

`ifdef GS_MAPPER_READBACK_EN
    logic [7:0] rb_q, rb_d;

    // Readback byte captured as the read cycle is accepted
    always_comb begin
        rb_d = rb_q;
        if (rd_start_c) begin
            rb_d = 8'(regs_q[z80.a[WIN_W-1:0]]);
        end
    end

    always_ff @(posedge clkin) begin
        if (coldres) begin
            rb_q <= 8'h00;
        end else begin
            rb_q <= rb_d;
        end
    end

    assign z80.d_oe  = rd_active && !coldres;
    assign z80.d_out = z80.d_oe ? rb_q : 8'h00;
`else
    logic unused_rb;
    assign unused_rb = ^{rd_start_c, rd_active};
    assign z80.d_oe  = 1'b0;
    assign z80.d_out = 8'h00;
`endif

    // Address bits between the window and port fields are not decoded
    assign unused_bits = ^{z80.a, z80.d_in};

endmodule
